// File: rtl/hazard_stall_ctrl_pkg.sv
// Shared pipeline package: FSM state encoding, register-index width
// and the MemRead "no load" constant used by the hazard logic.
package hazard_stall_ctrl_pkg;

    localparam int REG_W = 5;

    localparam logic [1:0] MEMREAD_NONE = 2'd0;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        FAULT    = 2'd2
    } hz_state_t;

endpackage

// File: rtl/hazard_stall_ctrl_hazard_detect.sv
// Combinational load-use compare between the ID instruction and a load in EX.
// Ports: ex_mem_read/ex_rd (EX load), id_rs/id_rt/id_uses_rt (ID sources) -> load_use.
module hazard_detect
    import hazard_stall_ctrl_pkg::*;
(
    input  logic [1:0]       ex_mem_read,
    input  logic [REG_W-1:0] ex_rd,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_uses_rt,
    output logic             load_use
);

    logic is_load;
    logic rd_live;
    logic rs_hit;
    logic rt_hit;

    assign is_load  = (ex_mem_read != MEMREAD_NONE);
    // r0 is hardwired zero, so a load into it never creates a dependency
    assign rd_live  = (ex_rd != '0);
    assign rs_hit   = (ex_rd == id_rs);
    assign rt_hit   = id_uses_rt && (ex_rd == id_rt);
    assign load_use = is_load && rd_live && (rs_hit || rt_hit);

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Pipeline hazard/stall controller: load-use bubbles, branch flush, memory waits,
// saturating stall counter and sticky memory-timeout fault.
// Ports: Clk/Reset, ID/EX register fields, branch_taken, mem_busy ->
// stage enables, bubble/flush/holds, stall_count, fault.
module hazard_stall_ctrl
    import hazard_stall_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 16
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_uses_rt,
    input  logic [REG_W-1:0] ex_rd,
    input  logic [1:0]       ex_mem_read,
    input  logic             branch_taken,
    input  logic             mem_busy,
    output logic             pc_write,
    output logic             if_id_write,
    output logic             if_id_flush,
    output logic             id_ex_bubble,
    output logic             id_ex_hold,
    output logic             ex_mem_hold,
    output logic [CNT_W-1:0] stall_count,
    output logic             fault
);

    localparam logic [7:0] TO_LAST = 8'(MEM_TIMEOUT - 1);

    hz_state_t  state;
    hz_state_t  state_next;
    logic [7:0] wait_cnt;
    logic [7:0] wait_next;
    logic       load_use;

    hazard_detect u_detect (
        .ex_mem_read (ex_mem_read),
        .ex_rd       (ex_rd),
        .id_rs       (id_rs),
        .id_rt       (id_rt),
        .id_uses_rt  (id_uses_rt),
        .load_use    (load_use)
    );

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state    <= RUN;
            wait_cnt <= '0;
        end else begin
            state    <= state_next;
            wait_cnt <= wait_next;
        end
    end

    always_comb begin
        pc_write     = 1'b1;
        if_id_write  = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_bubble = 1'b0;
        id_ex_hold   = 1'b0;
        ex_mem_hold  = 1'b0;
        state_next   = state;
        wait_next    = wait_cnt;

        case (state)
            RUN, MEM_WAIT: begin
                if (mem_busy) begin
                    pc_write    = 1'b0;
                    if_id_write = 1'b0;
                    id_ex_hold  = 1'b1;
                    ex_mem_hold = 1'b1;
                    if (state == RUN) begin
                        state_next = MEM_WAIT;
                        wait_next  = 8'd1;
                    end else begin
                        wait_next = wait_cnt + 8'd1;
                        if (wait_cnt == TO_LAST)
                            state_next = FAULT;
                    end
                end else begin
                    state_next = RUN;
                    // stall beats a same-cycle branch; branch re-evaluates next cycle
                    if (load_use) begin
                        pc_write     = 1'b0;
                        if_id_write  = 1'b0;
                        id_ex_bubble = 1'b1;
                    end else if (branch_taken) begin
                        if_id_flush = 1'b1;
                    end
                end
            end
            FAULT: begin
                pc_write    = 1'b0;
                if_id_write = 1'b0;
                id_ex_hold  = 1'b1;
                ex_mem_hold = 1'b1;
            end
            default: state_next = RUN;
        endcase

        if (Reset) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_bubble = 1'b1;
            if_id_flush  = 1'b1;
            id_ex_hold   = 1'b0;
            ex_mem_hold  = 1'b0;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            stall_count <= '0;
            fault       <= 1'b0;
        end else begin
            if (!pc_write && (stall_count != '1))
                stall_count <= stall_count + 1'b1;
            if (state_next == FAULT)
                fault <= 1'b1;
        end
    end

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed self-checking bench for hazard_stall_ctrl.
// Runs with MEM_TIMEOUT=4 and a 4-bit stall counter to reach saturation quickly.
module tb_hazard_stall_ctrl;

    logic       Clk;
    logic       Reset;
    logic [4:0] id_rs;
    logic [4:0] id_rt;
    logic       id_uses_rt;
    logic [4:0] ex_rd;
    logic [1:0] ex_mem_read;
    logic       branch_taken;
    logic       mem_busy;
    logic       pc_write;
    logic       if_id_write;
    logic       if_id_flush;
    logic       id_ex_bubble;
    logic       id_ex_hold;
    logic       ex_mem_hold;
    logic [3:0] stall_count;
    logic       fault;

    int n_vec = 0;
    int n_err = 0;

    hazard_stall_ctrl #(
        .MEM_TIMEOUT (4),
        .CNT_W       (4)
    ) dut (
        .Clk          (Clk),
        .Reset        (Reset),
        .id_rs        (id_rs),
        .id_rt        (id_rt),
        .id_uses_rt   (id_uses_rt),
        .ex_rd        (ex_rd),
        .ex_mem_read  (ex_mem_read),
        .branch_taken (branch_taken),
        .mem_busy     (mem_busy),
        .pc_write     (pc_write),
        .if_id_write  (if_id_write),
        .if_id_flush  (if_id_flush),
        .id_ex_bubble (id_ex_bubble),
        .id_ex_hold   (id_ex_hold),
        .ex_mem_hold  (ex_mem_hold),
        .stall_count  (stall_count),
        .fault        (fault)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic chk1(input string tag, input logic got, input logic exp);
        n_vec++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed %b expected %b", tag, got, exp);
        end
    endtask

    task automatic chkc(input string tag, input logic [3:0] got,
                        input logic [3:0] exp);
        n_vec++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic pw, input logic iw,
                           input logic bub, input logic fl,
                           input logic ih, input logic eh);
        chk1({tag, ".pc_write"}, pc_write, pw);
        chk1({tag, ".if_id_write"}, if_id_write, iw);
        chk1({tag, ".id_ex_bubble"}, id_ex_bubble, bub);
        chk1({tag, ".if_id_flush"}, if_id_flush, fl);
        chk1({tag, ".id_ex_hold"}, id_ex_hold, ih);
        chk1({tag, ".ex_mem_hold"}, ex_mem_hold, eh);
    endtask

    task automatic cyc();
        @(posedge Clk);
        #1;
    endtask

    task automatic idle();
        id_rs        = 5'd1;
        id_rt        = 5'd2;
        id_uses_rt   = 1'b0;
        ex_rd        = 5'd0;
        ex_mem_read  = 2'b00;
        branch_taken = 1'b0;
        mem_busy     = 1'b0;
    endtask

    initial begin
        Reset = 1'b1;
        idle();
        #2;
        chk_out("rst_comb", 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        cyc();
        chkc("rst_cnt", stall_count, 4'd0);
        chk1("rst_fault", fault, 1'b0);
        Reset = 1'b0;
        #1;
        chk_out("run_idle", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

        // basic load-use on rs
        ex_mem_read = 2'b01; ex_rd = 5'd5; id_rs = 5'd5;
        #1;
        chk_out("lu_rs", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        cyc();
        chkc("lu_rs_cnt", stall_count, 4'd1);

        // load into r0 never stalls
        idle();
        ex_mem_read = 2'b01; ex_rd = 5'd0; id_rs = 5'd0;
        #1;
        chk1("lu_r0", pc_write, 1'b1);

        // rt match only counts when rt is a source
        idle();
        ex_mem_read = 2'b10; ex_rd = 5'd7; id_rs = 5'd3; id_rt = 5'd7;
        #1;
        chk1("lu_rt_unused", pc_write, 1'b1);
        id_uses_rt = 1'b1;
        #1;
        chk_out("lu_rt_used", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        cyc();
        chkc("lu_rt_cnt", stall_count, 4'd2);

        // mem_busy for 3 cycles, release together with a branch
        idle();
        mem_busy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk_out("busy3", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
            cyc();
        end
        chkc("busy3_cnt", stall_count, 4'd5);
        mem_busy = 1'b0; branch_taken = 1'b1;
        #1;
        chk_out("busy3_rel", 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        cyc();
        chkc("busy3_rel_cnt", stall_count, 4'd5);
        chk1("busy3_fault", fault, 1'b0);

        // load-use and branch together: stall wins, branch next cycle
        idle();
        ex_mem_read = 2'b01; ex_rd = 5'd9; id_rs = 5'd9; branch_taken = 1'b1;
        #1;
        chk_out("lu_br", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        cyc();
        chkc("lu_br_cnt", stall_count, 4'd6);
        ex_mem_read = 2'b00; ex_rd = 5'd0;
        #1;
        chk_out("br_only", 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        cyc();
        chkc("br_only_cnt", stall_count, 4'd6);

        // timeout: 4 busy cycles -> FAULT
        idle();
        mem_busy = 1'b1;
        for (int i = 0; i < 3; i++) cyc();
        chk1("to_pre_fault", fault, 1'b0);
        chk1("to_4th_hold", ex_mem_hold, 1'b1);
        cyc();
        chk1("to_fault", fault, 1'b1);
        chkc("to_cnt", stall_count, 4'd10);
        mem_busy = 1'b0;
        #1;
        chk_out("fault_held", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 8; i++) cyc();
        chkc("cnt_sat", stall_count, 4'd15);
        chk1("fault_sticky", fault, 1'b1);

        // reset clears FAULT
        Reset = 1'b1;
        #1;
        chk_out("rst_fault_comb", 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        cyc();
        chk1("rst_fault_clr", fault, 1'b0);
        chkc("rst_fault_cnt", stall_count, 4'd0);
        Reset = 1'b0;
        #1;
        chk_out("post_fault_run", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

        // reset on the 2nd cycle of MEM_WAIT
        mem_busy = 1'b1;
        cyc();
        cyc();
        chkc("mw2_cnt", stall_count, 4'd2);
        Reset = 1'b1;
        #1;
        chk_out("mw2_rst", 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        cyc();
        chkc("mw2_rst_cnt", stall_count, 4'd0);
        chk1("mw2_rst_fault", fault, 1'b0);
        Reset = 1'b0; mem_busy = 1'b0;
        #1;
        chk_out("mw2_run", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc();
        chkc("mw2_run_cnt", stall_count, 4'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/hazard_stall_ctrl.md
# hazard_stall_ctrl

Pipeline hazard and stall controller for the 5-stage datapath. It detects load-use hazards between ID and EX and sequences multi-cycle data-memory waits. It generates PC / IF-ID / ID-EX / EX-MEM enables, the ID-EX bubble select and the IF-ID flush. It also keeps a saturating stall counter and a sticky memory-timeout fault.

## Interface
Parameters:
- MEM_TIMEOUT, 16: consecutive mem_busy cycles before FAULT; legal range 2..255.
- CNT_W, 16: width of stall_count.

Ports:
- Clk  in  1  clock; all state updates on rising edge.
- Reset  in  1  synchronous, active-high.
- id_rs  in  5  rs field of the instruction in ID.
- id_rt  in  5  rt field of the instruction in ID.
- id_uses_rt  in  1  ID instruction reads rt as a source.
- ex_rd  in  5  destination register of the instruction in EX (ID-EX output).
- ex_mem_read  in  2  ID-EX MemRead field; nonzero = load.
- branch_taken  in  1  taken branch/jump resolved in ID this cycle.
- mem_busy  in  1  data memory not ready; the MEM stage must hold.
- pc_write  out  1  PC load enable.
- if_id_write  out  1  IF-ID load enable.
- if_id_flush  out  1  IF-ID loads a NOP.
- id_ex_bubble  out  1  ID-EX control fields forced to 0 (RegWrite, MemWrite, MemRead, MemToReg, ALUOp).
- id_ex_hold  out  1  ID-EX keeps its contents.
- ex_mem_hold  out  1  EX-MEM keeps its contents.
- stall_count  out  CNT_W  cycles with pc_write=0, saturating.
- fault  out  1  sticky memory timeout.

## Operation
- load_use (combinational) = (ex_mem_read != 0) && (ex_rd != 0) && ((ex_rd == id_rs) || (id_uses_rt && ex_rd == id_rt)).
- FSM states are RUN, MEM_WAIT and FAULT. Reset state is RUN.
- RUN rules, in priority order:
  - mem_busy: pc_write=0, if_id_write=0, id_ex_hold=1, ex_mem_hold=1. Next state MEM_WAIT; wait_cnt<=1.
  - else load_use: pc_write=0, if_id_write=0, id_ex_bubble=1. One-cycle stall; the bubble clears the hazard, so no state change.
  - else branch_taken: if_id_flush=1, pc_write=1.
  - else all enables 1, all holds/bubble/flush 0.
- MEM_WAIT:
  - mem_busy=1: same outputs as the RUN mem_busy case; wait_cnt++. If wait_cnt == MEM_TIMEOUT-1, next state is FAULT.
  - mem_busy=0: evaluate the RUN rules (load_use/branch) this cycle; next state RUN.
- FAULT: pc_write=0, if_id_write=0, id_ex_hold=1, ex_mem_hold=1, fault=1. Exited only by Reset.
- Branches arriving in MEM_WAIT are not recorded. The instruction stays held in ID and branch_taken is re-evaluated on release.
- load_use together with branch_taken: the stall wins and there is no flush. The branch is re-evaluated next cycle.
- stall_count increments on each edge where pc_write=0 (FAULT included). It saturates at 2^CNT_W-1.
- wait_cnt width is 8 bits.

## Timing
- All outputs except stall_count and fault are combinational from state and inputs, valid in the same cycle.
- stall_count and fault are registered and update 1 cycle after the causing condition.
- While Reset=1, outputs are forced: pc_write=0, if_id_write=0, id_ex_bubble=1, if_id_flush=1, holds=0.
- On the edge with Reset=1: state=RUN, wait_cnt=0, stall_count=0, fault=0.
- Reset mid MEM_WAIT or in FAULT returns to RUN on that edge, overriding everything.
- Load-use stall costs exactly 1 cycle. A taken branch costs 1 flushed slot.
- FAULT is entered on the edge ending the MEM_TIMEOUT-th consecutive mem_busy cycle. fault reads 1 from the next cycle.
- mem_busy for N < MEM_TIMEOUT cycles stalls exactly N cycles. Release happens in the first cycle with mem_busy=0.

## Structure
- Shared pipeline package holds:
  - state encoding: RUN=2'd0, MEM_WAIT=2'd1, FAULT=2'd2;
  - register-index width (5);
  - the MemRead "no load" constant 2'd0.
- One sub-module, hazard_detect: purely combinational load_use compare, reusable by the forwarding unit.
- Top level holds the FSM, wait_cnt, stall_count and fault registers.

## Test plan
- ex_mem_read=2'b01, ex_rd=5, id_rs=5 for one cycle -> same cycle pc_write=0, if_id_write=0, id_ex_bubble=1; stall_count 0->1.
- Load with ex_rd=0 matching id_rs=0 -> no stall. ex_rd=7=id_rt with id_uses_rt=0 -> no stall; with id_uses_rt=1 -> stall.
- mem_busy high 3 cycles -> pc_write=0 and ex_mem_hold=1 for exactly 3 cycles; stall_count=3; state RUN after release.
- MEM_TIMEOUT=4, mem_busy held -> fault=1 after the 4th busy cycle; outputs stay held after mem_busy drops; Reset clears fault, stall_count and state.
- load_use and branch_taken in the same cycle -> bubble, if_id_flush=0; next cycle branch alone -> if_id_flush=1, pc_write=1.
- Reset asserted on the 2nd cycle of MEM_WAIT -> forced reset outputs. After release, RUN with stall_count=0.
